// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for 800x600 @ 60 Hz (40 MHz pixel clock).
// Produces pixel/line counters, sync, blanking and per-frame marker pulses,
// all registered on the same edge so every output describes the same pixel.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN enables the completed-frame
// counter on frame_cnt; without it frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic        vblnk_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Width-adjusted comparison constants for the 11-bit counters
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_frame_start;
  logic        r_vblnk_start;

  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_h_wrap;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_hb_next;
  logic        w_vb_next;
  logic        w_fs_next;
  logic        w_vbs_next;

  // Next-state counters and flag decode from the next counter values
  always_comb begin
    w_h_wrap = (r_hcount == H_LAST);
    w_h_next = r_hcount + 11'd1;
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_h_next = 11'd0;
      if (r_vcount == V_LAST) begin
        w_v_next = 11'd0;
      end else begin
        w_v_next = r_vcount + 11'd1;
      end
    end else begin
      w_v_next = r_vcount;
    end
    w_hs_act   = (w_h_next >= HS_BEG) && (w_h_next < HS_END);
    w_vs_act   = (w_v_next >= VS_BEG) && (w_v_next < VS_END);
    w_hb_next  = (w_h_next >= H_ACT);
    w_vb_next  = (w_v_next >= V_ACT);
    w_fs_next  = (w_h_next == 11'd0) && (w_v_next == 11'd0);
    w_vbs_next = (w_h_next == 11'd0) && (w_v_next == V_ACT);
  end

  // Counters and all flags registered together so they stay aligned
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblnk_start <= 1'b0;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_hblnk       <= w_hb_next;
      r_vblnk       <= w_vb_next;
      r_frame_start <= w_fs_next;
      r_vblnk_start <= w_vbs_next;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, bumps on the edge that raises frame_start
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_fs_next) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign frame_start = r_frame_start;
  assign vblnk_start = r_vblnk_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance, a default-timing
// instance with active-low syncs, and a shrunken raster instance so full
// frames fit in a short run.
module tb_vga_timing_gen;

  logic pclk;
  logic rst;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // default instance
  logic [10:0] d_h, d_v;
  logic d_hs, d_vs, d_hb, d_vb, d_fs, d_vbs;
  logic [15:0] d_fc;
  // active-low sync instance, default timing
  logic [10:0] n_h, n_v;
  logic n_hs, n_vs, n_hb, n_vb, n_fs, n_vbs;
  logic [15:0] n_fc;
  // small raster: H 8+2+3+3=16, V 6+1+2+2=11, frame 176 cycles
  logic [10:0] s_h, s_v;
  logic s_hs, s_vs, s_hb, s_vb, s_fs, s_vbs;
  logic [15:0] s_fc;

  vga_timing_gen u_dut (
    .pclk(pclk), .rst(rst), .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .frame_start(d_fs), .vblnk_start(d_vbs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
    .pclk(pclk), .rst(rst), .hcount(n_h), .vcount(n_v), .hsync(n_hs), .vsync(n_vs),
    .hblnk(n_hb), .vblnk(n_vb), .frame_start(n_fs), .vblnk_start(n_vbs), .frame_cnt(n_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .pclk(pclk), .rst(rst), .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .frame_start(s_fs), .vblnk_start(s_vbs), .frame_cnt(s_fc)
  );

  int checks = 0;
  int errors = 0;
  int e = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", nm, act, exp, e);
    end
  endtask

  // Hold reset for two cycles, release just after a falling edge
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    e = 0;
  endtask

  // Advance to edge n and sample on the following falling edge
  task automatic goto_edge(input int n);
    while (e < n) begin
      @(posedge pclk);
      e++;
    end
    @(negedge pclk);
  endtask

  typedef struct {
    int   ed;
    int   h;
    int   v;
    logic hs;
    logic hb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int hs_cnt;
    int fs_cnt;
    int vbs_cnt;
    int k, eh, ev, efc;

    tbl[0]  = '{ed: 1,    h: 1,    v: 0, hs: 1'b0, hb: 1'b0};
    tbl[1]  = '{ed: 2,    h: 2,    v: 0, hs: 1'b0, hb: 1'b0};
    tbl[2]  = '{ed: 3,    h: 3,    v: 0, hs: 1'b0, hb: 1'b0};
    tbl[3]  = '{ed: 799,  h: 799,  v: 0, hs: 1'b0, hb: 1'b0};
    tbl[4]  = '{ed: 800,  h: 800,  v: 0, hs: 1'b0, hb: 1'b1};
    tbl[5]  = '{ed: 839,  h: 839,  v: 0, hs: 1'b0, hb: 1'b1};
    tbl[6]  = '{ed: 840,  h: 840,  v: 0, hs: 1'b1, hb: 1'b1};
    tbl[7]  = '{ed: 967,  h: 967,  v: 0, hs: 1'b1, hb: 1'b1};
    tbl[8]  = '{ed: 968,  h: 968,  v: 0, hs: 1'b0, hb: 1'b1};
    tbl[9]  = '{ed: 1055, h: 1055, v: 0, hs: 1'b0, hb: 1'b1};
    tbl[10] = '{ed: 1056, h: 0,    v: 1, hs: 1'b0, hb: 1'b0};
    tbl[11] = '{ed: 1057, h: 1,    v: 1, hs: 1'b0, hb: 1'b0};
    tbl[12] = '{ed: 1856, h: 800,  v: 1, hs: 1'b0, hb: 1'b1};
    tbl[13] = '{ed: 1896, h: 840,  v: 1, hs: 1'b1, hb: 1'b1};
    tbl[14] = '{ed: 2111, h: 1055, v: 1, hs: 1'b0, hb: 1'b1};

    // Reset held: all outputs at reset values across several edges
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_hcount", {21'd0, d_h}, 32'd0);
    chk("rst_vcount", {21'd0, d_v}, 32'd0);
    chk("rst_hsync", {31'd0, d_hs}, 32'd0);
    chk("rst_vsync", {31'd0, d_vs}, 32'd0);
    chk("rst_hblnk", {31'd0, d_hb}, 32'd0);
    chk("rst_vblnk", {31'd0, d_vb}, 32'd0);
    chk("rst_fs", {31'd0, d_fs}, 32'd0);
    chk("rst_vbs", {31'd0, d_vbs}, 32'd0);
    chk("rst_fc", {16'd0, d_fc}, 32'd0);
    chk("rst_neg_hsync", {31'd0, n_hs}, 32'd1);
    chk("rst_neg_vsync", {31'd0, n_vs}, 32'd1);

    // Default-timing line checks from the vector table
    rst = 1'b1;
    e = 0;
    for (int i = 0; i < 15; i++) begin
      goto_edge(tbl[i].ed);
      chk("tbl_hcount", {21'd0, d_h}, tbl[i].h);
      chk("tbl_vcount", {21'd0, d_v}, tbl[i].v);
      chk("tbl_hsync", {31'd0, d_hs}, {31'd0, tbl[i].hs});
      chk("tbl_hblnk", {31'd0, d_hb}, {31'd0, tbl[i].hb});
      chk("tbl_vsync", {31'd0, d_vs}, 32'd0);
      chk("tbl_vblnk", {31'd0, d_vb}, 32'd0);
      chk("tbl_neg_hsync", {31'd0, n_hs}, {31'd0, ~tbl[i].hs});
      chk("tbl_neg_vsync", {31'd0, n_vs}, 32'd1);
      chk("tbl_neg_hcount", {21'd0, n_h}, tbl[i].h);
      chk("tbl_neg_hblnk", {31'd0, n_hb}, {31'd0, tbl[i].hb});
    end

    // hsync width over a whole line (line 2: edges 2112..3167)
    hs_cnt = 0;
    goto_edge(2112);
    chk("line2_start_h", {21'd0, d_h}, 32'd0);
    chk("line2_start_v", {21'd0, d_v}, 32'd2);
    for (int i = 0; i < 1056; i++) begin
      if (i > 0) goto_edge(2112 + i);
      if (d_hs === 1'b1) hs_cnt++;
    end
    chk("hsync_width", hs_cnt, 32'd128);

    // Small raster: three full frames against an edge-index model
    do_reset();
    fs_cnt = 0;
    vbs_cnt = 0;
    for (int i = 1; i <= 530; i++) begin
      goto_edge(i);
      k   = i;
      eh  = k % 16;
      ev  = (k / 16) % 11;
`ifdef VGA_TIMING_FRAME_CNT_EN
      efc = k / 176;
`else
      efc = 0;
`endif
      chk("s_hcount", {21'd0, s_h}, eh);
      chk("s_vcount", {21'd0, s_v}, ev);
      chk("s_hsync", {31'd0, s_hs}, (eh >= 10 && eh < 13) ? 32'd1 : 32'd0);
      chk("s_vsync", {31'd0, s_vs}, (ev >= 7 && ev < 9) ? 32'd1 : 32'd0);
      chk("s_hblnk", {31'd0, s_hb}, (eh >= 8) ? 32'd1 : 32'd0);
      chk("s_vblnk", {31'd0, s_vb}, (ev >= 6) ? 32'd1 : 32'd0);
      chk("s_fs", {31'd0, s_fs}, (eh == 0 && ev == 0) ? 32'd1 : 32'd0);
      chk("s_vbs", {31'd0, s_vbs}, (eh == 0 && ev == 6) ? 32'd1 : 32'd0);
      chk("s_fc", {16'd0, s_fc}, efc);
      if (s_fs === 1'b1) fs_cnt++;
      if (s_vbs === 1'b1) vbs_cnt++;
      chk("d_fs_quiet", {31'd0, d_fs}, 32'd0);
    end
    chk("s_fs_count", fs_cnt, 32'd3);
    chk("s_vbs_count", vbs_cnt, 32'd3);

    // Mid-frame asynchronous reset on the small raster at (5,3)
    do_reset();
    goto_edge(53);
    chk("mid_pre_h", {21'd0, s_h}, 32'd5);
    chk("mid_pre_v", {21'd0, s_v}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async_h", {21'd0, s_h}, 32'd0);
    chk("mid_async_v", {21'd0, s_v}, 32'd0);
    chk("mid_async_hb", {31'd0, s_hb}, 32'd0);
    chk("mid_async_d_h", {21'd0, d_h}, 32'd0);
    chk("mid_async_d_hs", {31'd0, d_hs}, 32'd0);
    chk("mid_async_n_hs", {31'd0, n_hs}, 32'd1);
    @(negedge pclk);
    rst = 1'b1;
    e = 0;
    for (int i = 1; i <= 3; i++) begin
      goto_edge(i);
      chk("resume_s_h", {21'd0, s_h}, i);
      chk("resume_s_v", {21'd0, s_v}, 32'd0);
      chk("resume_d_h", {21'd0, d_h}, i);
      chk("resume_d_v", {21'd0, d_v}, 32'd0);
      chk("resume_s_fc", {16'd0, s_fc}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
